sha1_iter_core: RTL

SHA1_ITER_CORE -- requirements
Module: sha1_iter_core

---
 rtl/sha1_iter_core.sv | 141 ++++++++++++++
 1 files changed

// File: rtl/sha1_iter_core.sv
// Iterative SHA-1 compression core, RPC rounds per clock, 16-word rolling schedule window.
// Optional macro SHA1_ITER_CORE_INIT_IN_EN adds in_init, loaded instead of the IV on in_first blocks.
module sha1_iter_core #(
  parameter int RPC = 1
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [511:0] in_data,
  input  logic         in_first,
`ifdef SHA1_ITER_CORE_INIT_IN_EN
  input  logic [159:0] in_init,
`endif
  output logic         out_valid,
  input  logic         out_ready,
  output logic [159:0] out_digest,
  output logic         busy
);
  localparam logic [159:0] IV = 160'h67452301_EFCDAB89_98BADCFE_10325476_C3D2E1F0;

  if (!(RPC == 1 || RPC == 2 || RPC == 4 || RPC == 5 || RPC == 8 ||
        RPC == 10 || RPC == 16 || RPC == 20 || RPC == 40 || RPC == 80)) begin : g_bad_rpc
    $error("sha1_iter_core: RPC must be one of 1,2,4,5,8,10,16,20,40,80");
  end

  typedef enum logic [1:0] {S_IDLE, S_ROUND, S_DONE} state_t;

  state_t       r_state;
  logic [6:0]   r_t;
  logic [31:0]  r_w [16];
  logic [31:0]  r_a, r_b, r_c, r_d, r_e;
  logic [159:0] r_h;
  logic [159:0] r_cv;
  logic         r_in_rdy, r_busy, r_out_valid;

  logic [31:0]  w_a, w_b, w_c, w_d, w_e;
  logic [31:0]  w_win [16];
  logic [159:0] w_chain, w_sum;
  logic         w_last;

`ifdef SHA1_ITER_CORE_INIT_IN_EN
  assign w_chain = in_first ? in_init : r_h;
`else
  assign w_chain = in_first ? IV : r_h;
`endif

  // Unrolled RPC rounds; r_w[0] is always W[t], the window shifts one word per round.
  always_comb begin
    logic [31:0] a, b, c, d, e, f, k, tmp, nw;
    logic [31:0] win [16];
    int          tk;
    a = r_a; b = r_b; c = r_c; d = r_d; e = r_e;
    win = r_w;
    for (int i = 0; i < RPC; i++) begin
      tk = int'(r_t) + i;
      if (tk < 20) begin
        f = (b & c) | (~b & d);          k = 32'h5A827999;
      end else if (tk < 40) begin
        f = b ^ c ^ d;                   k = 32'h6ED9EBA1;
      end else if (tk < 60) begin
        f = (b & c) | (b & d) | (c & d); k = 32'h8F1BBCDC;
      end else begin
        f = b ^ c ^ d;                   k = 32'hCA62C1D6;
      end
      tmp = {a[26:0], a[31:27]} + f + e + k + win[0];
      nw  = win[13] ^ win[8] ^ win[2] ^ win[0];
      e = d;
      d = c;
      c = {b[1:0], b[31:2]};
      b = a;
      a = tmp;
      for (int j = 0; j < 15; j++) win[j] = win[j+1];
      win[15] = {nw[30:0], nw[31]};
    end
    w_a = a; w_b = b; w_c = c; w_d = d; w_e = e;
    w_win = win;
  end

  assign w_last = (r_t == 7'(80 - RPC));
  assign w_sum  = {r_cv[159:128] + w_a, r_cv[127:96] + w_b, r_cv[95:64] + w_c,
                   r_cv[63:32]   + w_d, r_cv[31:0]   + w_e};

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state     <= S_IDLE;
      r_t         <= '0;
      r_w         <= '{default: '0};
      r_a         <= '0;
      r_b         <= '0;
      r_c         <= '0;
      r_d         <= '0;
      r_e         <= '0;
      r_h         <= IV;
      r_cv        <= IV;
      r_in_rdy    <= 1'b1;
      r_busy      <= 1'b0;
      r_out_valid <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: if (in_valid) begin
          r_state  <= S_ROUND;
          r_in_rdy <= 1'b0;
          r_busy   <= 1'b1;
          r_t      <= '0;
          r_cv     <= w_chain;
          {r_a, r_b, r_c, r_d, r_e} <= w_chain;
          for (int i = 0; i < 16; i++) r_w[i] <= in_data[511-32*i -: 32];
        end
        S_ROUND: begin
          r_a <= w_a;
          r_b <= w_b;
          r_c <= w_c;
          r_d <= w_d;
          r_e <= w_e;
          r_w <= w_win;
          r_t <= r_t + 7'(RPC);
          if (w_last) begin
            r_h         <= w_sum;
            r_state     <= S_DONE;
            r_busy      <= 1'b0;
            r_out_valid <= 1'b1;
          end
        end
        S_DONE: if (out_ready) begin
          r_state     <= S_IDLE;
          r_out_valid <= 1'b0;
          r_in_rdy    <= 1'b1;
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  // r_in_rdy resets high so the core is ready the first cycle after reset drops.
  assign in_ready   = r_in_rdy & ~rst;
  assign out_valid  = r_out_valid;
  assign busy       = r_busy;
  assign out_digest = r_h;

endmodule
